// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: FSM state encoding and slave select codes.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int SLV_GPIO = 0;
   localparam int SLV_UART = 1;

   localparam logic [1:0] PSEL_GPIO = 2'b01;
   localparam logic [1:0] PSEL_UART = 2'b10;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired_o flags the last permitted wait cycle.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Saturate at the terminal count so a late abort cannot wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready request into SETUP/ACCESS transfers with a one-cycle response.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NSLV           = 2,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int SLV_W         = (NSLV > 1) ? $clog2(NSLV) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [SLV_W-1:0]  req_slave,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [NSLV-1:0]   psel,
   output logic              pen,
   output logic              pwr,
   output logic [ADDR_W-1:0] pAdd,
   output logic [DATA_W-1:0] pwData,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   apb_state_e        state_q;
   logic [NSLV-1:0]   psel_q;
   logic              pen_q;
   logic              pwr_q;
   logic [ADDR_W-1:0] pAdd_q;
   logic [DATA_W-1:0] pwData_q;
   logic              rspValid_q;
   logic [DATA_W-1:0] rspRdata_q;
   logic              rspErr_q;
   logic              badSlv_q;
   logic              timeoutHit;

`ifdef APB_TIMEOUT_EN
   apb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (state_q == SETUP),
      .enable_i  ((state_q == ACCESS) && !pready),
      .expired_o (timeoutHit)
   );
`else
   assign timeoutHit = 1'b0;
`endif

   assign req_ready = (state_q == IDLE) && rst_n;
   assign psel      = psel_q;
   assign pen       = pen_q;
   assign pwr       = pwr_q;
   assign pAdd      = pAdd_q;
   assign pwData    = pwData_q;
   assign rsp_valid = rspValid_q;
   assign rsp_rdata = rspRdata_q;
   assign rsp_err   = rspErr_q;

   // An out-of-range slave still walks SETUP/ACCESS with no select so the requester gets an error response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         psel_q     <= '0;
         pen_q      <= 1'b0;
         pwr_q      <= 1'b0;
         pAdd_q     <= '0;
         pwData_q   <= '0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspErr_q   <= 1'b0;
         badSlv_q   <= 1'b0;
      end else begin
         rspValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  pAdd_q   <= req_addr;
                  pwData_q <= req_wdata;
                  pwr_q    <= req_write;
                  if (int'(req_slave) < NSLV) begin
                     psel_q   <= NSLV'(1) << req_slave;
                     badSlv_q <= 1'b0;
                  end else begin
                     psel_q   <= '0;
                     badSlv_q <= 1'b1;
                  end
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               pen_q   <= 1'b1;
               state_q <= ACCESS;
            end
            ACCESS: begin
               // pready wins over a simultaneous timeout on the terminal cycle.
               if (badSlv_q || pready || timeoutHit) begin
                  psel_q     <= '0;
                  pen_q      <= 1'b0;
                  rspValid_q <= 1'b1;
                  rspErr_q   <= badSlv_q || !pready;
                  if (!badSlv_q && pready && !pwr_q) begin
                     rspRdata_q <= prdata;
                  end
                  state_q <= IDLE;
               end
            end
            default: begin
               psel_q  <= '0;
               pen_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
